dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter that shares the single data-memory port between the core's load/store path and an external host port (debug/loader/DMA). The core has default priority. A starvation counter guarantees the host a slot after a bounded number of contested cycles. The block sits between the decoder/ALU address path and `mem`, stalls the core when it loses arbitration, and returns registered read responses to the host with a valid pulse.

## Interface
Parameters:
- `AddrWidth`, default 12: byte-address width presented to memory (matches `DMemAddrWidth`).
- `MaxCoreBurst`, default 4: number of consecutive contested cycles the core may win before the host is forced in. Legal range is 1–15.

Ports:
- `clk` input, 1: system clock. All state updates on the rising edge.
- `reset` input, 1: asynchronous, active-low reset.
- `core_req` input, 1: core load/store this cycle.
- `core_we` input, 1: core store.
- `core_addr` input, AddrWidth: core byte address.
- `core_wdata` input, 32: core store data.
- `core_width` input, mem_width_t: core access width.
- `core_sign_extend` input, 1: core load sign extension.
- `core_rdata` output, 32: `mem_data_out` passed through combinationally.
- `core_stall` output, 1: core lost arbitration this cycle and must hold its PC and instruction.
- `host_req` input, 1: host access request. Held stable until granted.
- `host_we` input, 1: host write.
- `host_addr` input, AddrWidth: host byte address.
- `host_wdata` input, 32: host write data.
- `host_width` input, mem_width_t: host access width. Host loads always zero-extend.
- `host_gnt` output, 1: host request accepted this cycle (combinational).
- `host_rvalid` output, 1: one-cycle response pulse, asserted the cycle after `host_gnt`.
- `host_rdata` output, 32: registered read data, valid while `host_rvalid` is high.
- `mem_write_enable` output, 1: to `mem`.
- `mem_address` output, AddrWidth: to `mem`.
- `mem_data_in` output, 32: to `mem`.
- `mem_width` output, mem_width_t: to `mem`.
- `mem_sign_extend` output, 1: to `mem`.
- `mem_data_out` input, 32: from `mem`, combinational read.
- `mem_alignment_error` input, 1: from `mem`.

## Operation
Arbitration, combinational in the current cycle:
- Only `core_req` asserted: the core is granted.
- Only `host_req` asserted: the host is granted.
- Both asserted: the core is granted unless `starve_cnt == MaxCoreBurst`, in which case the host is granted.
- Neither asserted: no grant.

Derived outputs:
- `core_stall = core_req & ~core_gnt`.
- `host_gnt = host_req & host_win`.

Memory port mux:
- The winner's address, width, write data and sign extension drive the `mem_*` outputs. Sign extension is forced to 0 when the host wins.
- `mem_write_enable = winner_we & (grant valid)`.
- With no grant, the core fields drive the port and `mem_write_enable = 0`.

Starvation counter (`starve_cnt`, 4 bits):
- Increments when the core wins while `host_req` is high, saturating at MaxCoreBurst.
- Clears to 0 on `host_gnt` or when `host_req` is low.

Host response register:
- On `host_gnt`, `host_rvalid` is set for the next cycle.
- `host_rdata` captures `mem_data_out` for reads and 0 for writes.
- `host_rvalid` returns to 0 after one cycle unless another grant occurs.
- Back-to-back host grants produce back-to-back `host_rvalid` pulses.

Reset:
- Asserting `reset` low clears `starve_cnt`, `host_rvalid` and `host_rdata` immediately, whether or not an access is in flight.
- A grant made in the cycle reset asserts produces no response.

## Timing
- Grant, stall and `mem_*` outputs: 0-cycle combinational paths from the request inputs.
- `host_rvalid`/`host_rdata`: exactly 1 cycle after `host_gnt`.
- Worst-case host wait under continuous core traffic: MaxCoreBurst + 1 cycles from `host_req` rising to `host_gnt`.
- Worst-case core stall: 1 cycle per forced host slot. A core stall never exceeds 1 consecutive cycle.
- All registered outputs reset to 0.

## Configuration
- `DMEM_ARB_ERR_EN` defined:
  - Adds output `host_err` (1 bit), registered alongside `host_rvalid`. It equals `mem_alignment_error` sampled during the host grant cycle.
  - Adds output `core_err_sticky` (1 bit). It is set when `mem_alignment_error` is high during a core grant and cleared only by reset.
- `DMEM_ARB_ERR_EN` undefined: neither port nor its logic exists. `mem_alignment_error` is left unconnected inside the block.

## Test plan
- Host read only: `host_req=1`, `host_addr=0x010`, memory word `0xDEADBEEF` -> `host_gnt=1` in the same cycle; next cycle `host_rvalid=1`, `host_rdata=0xDEADBEEF`, `core_stall=0`.
- Continuous contention with MaxCoreBurst=4: `core_req` and `host_req` held high -> core wins cycles 0–3, host wins cycle 4 (`core_stall=1` for that cycle only), pattern repeats every 5 cycles.
- Host write: word `0x12345678` to `0x020`, then host read of `0x020` -> write response `host_rdata=0`, `mem_write_enable=1` in the grant cycle only; read returns `0x12345678`.
- Core store while host idle: `core_we=1`, `core_addr=0x004` -> `mem_write_enable=1` and `mem_address=0x004`; `starve_cnt` stays 0.
- Reset mid-operation: assert `reset` low in the cycle after `host_gnt` -> `host_rvalid` drops to 0 immediately; after release the first contested cycle goes to the core.
- With `DMEM_ARB_ERR_EN` defined, host word read at `0x002` -> `host_err=1` together with `host_rvalid`; a misaligned core load sets `core_err_sticky`, which stays at 1 until reset.

Source files
------------

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single data-memory port between the core load/store path and an
// external host port (debug / loader / DMA). The core has default priority; a
// starvation counter forces a host slot after MaxCoreBurst contested cycles
// the core has won. Host reads come back registered, one cycle after the
// grant, with a single-cycle valid pulse.
//
// Optional feature macro: DMEM_ARB_ERR_EN
//   defined   -> adds host_err (registered with host_rvalid) and
//                core_err_sticky (set on a misaligned core access, cleared
//                only by reset).
//   undefined -> neither port exists and mem_alignment_error is not used.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   core_*                core request (req/we/addr/wdata/width/sign_extend)
//   core_rdata            mem_data_out passed straight through
//   core_stall            core requested but lost arbitration this cycle
//   host_*                host request (req/we/addr/wdata/width)
//   host_gnt              host request accepted this cycle (combinational)
//   host_rvalid/rdata     registered response, one cycle after host_gnt
//   mem_*                 shared memory port (outputs) and read/error inputs
//
// Handshake: the host raises host_req with stable we/addr/wdata/width and keeps
// them stable until host_gnt is seen high in the same cycle; that cycle is the
// transfer. Exactly one cycle later host_rvalid pulses with host_rdata (read
// data, or 0 for a write). There is no back-pressure on the response.
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;
  typedef enum logic [1:0] {
    WIDTH_BYTE = 2'd0,
    WIDTH_HALF = 2'd1,
    WIDTH_WORD = 2'd2
  } mem_width_t;
endpackage

module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned AddrWidth    = 12,
  parameter int unsigned MaxCoreBurst = 4   // legal range 1..15
) (
  input  logic                 clk,
  input  logic                 reset,

  input  logic                 core_req,
  input  logic                 core_we,
  input  logic [AddrWidth-1:0] core_addr,
  input  logic [31:0]          core_wdata,
  input  mem_width_t           core_width,
  input  logic                 core_sign_extend,
  output logic [31:0]          core_rdata,
  output logic                 core_stall,

  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [AddrWidth-1:0] host_addr,
  input  logic [31:0]          host_wdata,
  input  mem_width_t           host_width,
  output logic                 host_gnt,
  output logic                 host_rvalid,
  output logic [31:0]          host_rdata,
`ifdef DMEM_ARB_ERR_EN
  output logic                 host_err,
  output logic                 core_err_sticky,
`endif

  output logic                 mem_write_enable,
  output logic [AddrWidth-1:0] mem_address,
  output logic [31:0]          mem_data_in,
  output mem_width_t           mem_width,
  output logic                 mem_sign_extend,
  input  logic [31:0]          mem_data_out,
  input  logic                 mem_alignment_error
);

  localparam logic [3:0] BurstLimit = 4'(MaxCoreBurst);

  // Registered state
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        host_rvalid_q, host_rvalid_d;
  logic [31:0] host_rdata_q, host_rdata_d;

  // Arbitration results
  logic core_gnt;
  logic host_win;
  logic host_forced;

  // ---------------------------------------------------------------------------
  // Arbitration: core wins contested cycles until the counter reaches the
  // burst limit, at which point the host takes exactly one slot.
  // ---------------------------------------------------------------------------
  always_comb begin
    core_gnt    = 1'b0;
    host_win    = 1'b0;
    host_forced = (starve_cnt_q == BurstLimit);
    unique case ({core_req, host_req})
      2'b10:   core_gnt = 1'b1;
      2'b01:   host_win = 1'b1;
      2'b11: begin
        if (host_forced) host_win = 1'b1;
        else             core_gnt = 1'b1;
      end
      default: ;
    endcase
  end

  assign host_gnt   = host_req & host_win;
  assign core_stall = core_req & ~core_gnt;
  assign core_rdata = mem_data_out;

  // ---------------------------------------------------------------------------
  // Memory port mux. With no grant the core fields still drive the port so
  // the address path stays quiet, but the write enable is held low.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_address      = core_addr;
    mem_data_in      = core_wdata;
    mem_width        = core_width;
    mem_sign_extend  = core_sign_extend;
    mem_write_enable = core_we & core_gnt;
    if (host_win) begin
      mem_address      = host_addr;
      mem_data_in      = host_wdata;
      mem_width        = host_width;
      mem_sign_extend  = 1'b0;          // host loads always zero-extend
      mem_write_enable = host_we;
    end
  end

  // ---------------------------------------------------------------------------
  // Starvation counter: counts core wins while the host waits, saturating at
  // the burst limit. Any cycle without a pending host request, or the host
  // grant itself, restarts the count.
  // ---------------------------------------------------------------------------
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!host_req || host_gnt) begin
      starve_cnt_d = 4'd0;
    end else if (core_gnt && (starve_cnt_q != BurstLimit)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Host response: pulse valid one cycle after each grant; data holds between
  // grants so it stays stable for inspection.
  // ---------------------------------------------------------------------------
  always_comb begin
    host_rvalid_d = host_gnt;
    host_rdata_d  = host_rdata_q;
    if (host_gnt) begin
      host_rdata_d = host_we ? 32'd0 : mem_data_out;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_q  <= 4'd0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= 32'd0;
    end else begin
      starve_cnt_q  <= starve_cnt_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_q;

`ifdef DMEM_ARB_ERR_EN
  // ---------------------------------------------------------------------------
  // Error reporting: host error travels with the response pulse; the core
  // error is sticky until reset so software can poll it later.
  // ---------------------------------------------------------------------------
  logic host_err_q, host_err_d;
  logic core_err_sticky_q, core_err_sticky_d;

  always_comb begin
    host_err_d        = host_gnt & mem_alignment_error;
    core_err_sticky_d = core_err_sticky_q | (core_gnt & mem_alignment_error);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      host_err_q        <= 1'b0;
      core_err_sticky_q <= 1'b0;
    end else begin
      host_err_q        <= host_err_d;
      core_err_sticky_q <= core_err_sticky_d;
    end
  end

  assign host_err        = host_err_q;
  assign core_err_sticky = core_err_sticky_q;
`else
  // Alignment error is not consumed in this build.
  logic unused_alignment_error;
  assign unused_alignment_error = mem_alignment_error;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed bench for dmem_arbiter (AddrWidth=12, MaxCoreBurst=4). A small
// word-addressed memory model answers the shared port combinationally and
// takes writes on the rising edge. Inputs change 1 time unit after the rising
// edge; outputs are sampled 1 time unit after that (combinational) or 1 time
// unit after the next rising edge (registered).
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int AW = 12;

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // DUT signals
  logic          core_req, core_we, core_sign_extend;
  logic [AW-1:0] core_addr;
  logic [31:0]   core_wdata, core_rdata;
  mem_width_t    core_width;
  logic          core_stall;
  logic          host_req, host_we;
  logic [AW-1:0] host_addr;
  logic [31:0]   host_wdata;
  mem_width_t    host_width;
  logic          host_gnt, host_rvalid;
  logic [31:0]   host_rdata;
  logic          mem_write_enable, mem_sign_extend;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_data_in, mem_data_out;
  mem_width_t    mem_width;
  logic          mem_alignment_error;
`ifdef DMEM_ARB_ERR_EN
  logic          host_err, core_err_sticky;
`endif

  dmem_arbiter #(.AddrWidth(AW), .MaxCoreBurst(4)) dut (
    .clk                 (clk),
    .reset               (reset),
    .core_req            (core_req),
    .core_we             (core_we),
    .core_addr           (core_addr),
    .core_wdata          (core_wdata),
    .core_width          (core_width),
    .core_sign_extend    (core_sign_extend),
    .core_rdata          (core_rdata),
    .core_stall          (core_stall),
    .host_req            (host_req),
    .host_we             (host_we),
    .host_addr           (host_addr),
    .host_wdata          (host_wdata),
    .host_width          (host_width),
    .host_gnt            (host_gnt),
    .host_rvalid         (host_rvalid),
    .host_rdata          (host_rdata),
`ifdef DMEM_ARB_ERR_EN
    .host_err            (host_err),
    .core_err_sticky     (core_err_sticky),
`endif
    .mem_write_enable    (mem_write_enable),
    .mem_address         (mem_address),
    .mem_data_in         (mem_data_in),
    .mem_width           (mem_width),
    .mem_sign_extend     (mem_sign_extend),
    .mem_data_out        (mem_data_out),
    .mem_alignment_error (mem_alignment_error)
  );

  // Memory model: 16 words covering byte addresses 0x000..0x03F
  logic [31:0] mem_words [0:15];
  assign mem_data_out = mem_words[mem_address[5:2]];
  assign mem_alignment_error = ((mem_width == WIDTH_WORD) && (mem_address[1:0] != 2'b00)) ||
                               ((mem_width == WIDTH_HALF) && mem_address[0]);
  always @(posedge clk) begin
    if (mem_write_enable) mem_words[mem_address[5:2]] <= mem_data_in;
  end

  // Scoreboard counters
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem_words[i] = 32'h0;
    mem_words[4] = 32'hDEAD_BEEF;   // byte address 0x010

    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
    core_width = WIDTH_WORD; core_sign_extend = 0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    host_width = WIDTH_WORD;

    // ---- reset state ----
    reset = 0;
    settle();
    check("rst_rvalid", 32'(host_rvalid), 32'd0);
    check("rst_rdata", host_rdata, 32'd0);
    check("rst_gnt", 32'(host_gnt), 32'd0);
    check("rst_stall", 32'(core_stall), 32'd0);
    check("rst_we", 32'(mem_write_enable), 32'd0);
    tick(); tick();
    reset = 1;
    tick();

    // ---- host read only ----
    host_req = 1; host_addr = 12'h010;
    settle();
    check("hrd_gnt", 32'(host_gnt), 32'd1);
    check("hrd_stall", 32'(core_stall), 32'd0);
    check("hrd_addr", 32'(mem_address), 32'h010);
    check("hrd_we", 32'(mem_write_enable), 32'd0);
    tick();
    check("hrd_rvalid", 32'(host_rvalid), 32'd1);
    check("hrd_rdata", host_rdata, 32'hDEAD_BEEF);
    host_req = 0;
    tick();
    check("hrd_rvalid_drop", 32'(host_rvalid), 32'd0);

    // ---- continuous contention: core 4 cycles, host 1, repeating ----
    core_req = 1; core_we = 0; core_addr = 12'h004; core_sign_extend = 1;
    core_width = WIDTH_WORD;
    host_req = 1; host_we = 0; host_addr = 12'h010; host_width = WIDTH_HALF;
    for (int c = 0; c < 10; c++) begin
      settle();
      check($sformatf("cont_gnt_%0d", c), 32'(host_gnt), (c % 5 == 4) ? 32'd1 : 32'd0);
      check($sformatf("cont_stall_%0d", c), 32'(core_stall), (c % 5 == 4) ? 32'd1 : 32'd0);
      check($sformatf("cont_addr_%0d", c), 32'(mem_address), (c % 5 == 4) ? 32'h010 : 32'h004);
      check($sformatf("cont_sext_%0d", c), 32'(mem_sign_extend), (c % 5 == 4) ? 32'd0 : 32'd1);
      check($sformatf("cont_width_%0d", c), 32'(mem_width),
            (c % 5 == 4) ? 32'(WIDTH_HALF) : 32'(WIDTH_WORD));
      tick();
      check($sformatf("cont_rvalid_%0d", c), 32'(host_rvalid), (c % 5 == 4) ? 32'd1 : 32'd0);
      if (c % 5 == 4) check($sformatf("cont_rdata_%0d", c), host_rdata, 32'hDEAD_BEEF);
    end
    core_req = 0; host_req = 0; core_sign_extend = 0; host_width = WIDTH_WORD;
    tick();

    // ---- host write then read-back ----
    host_req = 1; host_we = 1; host_addr = 12'h020; host_wdata = 32'h1234_5678;
    settle();
    check("hwr_gnt", 32'(host_gnt), 32'd1);
    check("hwr_we", 32'(mem_write_enable), 32'd1);
    check("hwr_addr", 32'(mem_address), 32'h020);
    check("hwr_data", mem_data_in, 32'h1234_5678);
    tick();
    check("hwr_rvalid", 32'(host_rvalid), 32'd1);
    check("hwr_rdata", host_rdata, 32'd0);
    host_we = 0;
    settle();
    check("hrb_we", 32'(mem_write_enable), 32'd0);
    check("hrb_gnt", 32'(host_gnt), 32'd1);
    tick();
    check("hrb_rvalid_b2b", 32'(host_rvalid), 32'd1);
    check("hrb_rdata", host_rdata, 32'h1234_5678);
    host_req = 0;
    settle();
    check("hrb_idle_we", 32'(mem_write_enable), 32'd0);
    tick();
    check("hrb_rvalid_drop", 32'(host_rvalid), 32'd0);

    // ---- core store while host idle ----
    core_req = 1; core_we = 1; core_addr = 12'h004; core_wdata = 32'hCAFE_F00D;
    core_sign_extend = 1;
    settle();
    check("cst_we", 32'(mem_write_enable), 32'd1);
    check("cst_addr", 32'(mem_address), 32'h004);
    check("cst_data", mem_data_in, 32'hCAFE_F00D);
    check("cst_sext", 32'(mem_sign_extend), 32'd1);
    check("cst_gnt", 32'(host_gnt), 32'd0);
    check("cst_stall", 32'(core_stall), 32'd0);
    tick();
    // Counter must still be 0: host needs four more core wins before its slot.
    core_we = 0; core_sign_extend = 0;
    host_req = 1; host_addr = 12'h004;
    for (int c = 0; c < 5; c++) begin
      settle();
      if (c == 0) check("cst_core_rdata", core_rdata, 32'hCAFE_F00D);
      check($sformatf("cst_gnt_%0d", c), 32'(host_gnt), (c == 4) ? 32'd1 : 32'd0);
      tick();
    end
    check("cst_host_rdata", host_rdata, 32'hCAFE_F00D);
    core_req = 0; host_req = 0;
    tick();

    // ---- no grant: core fields on the port, write enable low ----
    core_req = 0; core_we = 1; core_addr = 12'h03C;
    settle();
    check("idle_we", 32'(mem_write_enable), 32'd0);
    check("idle_addr", 32'(mem_address), 32'h03C);
    core_we = 0;
    tick();

    // ---- reset mid-operation ----
    host_req = 1; host_addr = 12'h010;
    settle();
    check("rmid_gnt", 32'(host_gnt), 32'd1);
    tick();
    check("rmid_rvalid", 32'(host_rvalid), 32'd1);
    reset = 0;
    settle();
    check("rmid_rvalid_async", 32'(host_rvalid), 32'd0);
    check("rmid_rdata_async", host_rdata, 32'd0);
    tick();
    check("rmid_rvalid_held", 32'(host_rvalid), 32'd0);
    reset = 1;
    core_req = 1;
    settle();
    check("rmid_first_core", 32'(host_gnt), 32'd0);
    check("rmid_first_stall", 32'(core_stall), 32'd0);
    tick();
    check("rmid_after_rvalid", 32'(host_rvalid), 32'd0);
    core_req = 0; host_req = 0;
    tick();

`ifdef DMEM_ARB_ERR_EN
    // ---- alignment errors ----
    host_req = 1; host_addr = 12'h002; host_width = WIDTH_WORD;
    tick();
    check("err_host_rvalid", 32'(host_rvalid), 32'd1);
    check("err_host_err", 32'(host_err), 32'd1);
    host_req = 0;
    core_req = 1; core_addr = 12'h002; core_width = WIDTH_WORD;
    tick();
    check("err_core_set", 32'(core_err_sticky), 32'd1);
    core_addr = 12'h004;
    tick();
    check("err_core_hold", 32'(core_err_sticky), 32'd1);
    check("err_host_clear", 32'(host_err), 32'd0);
    core_req = 0;
    reset = 0;
    settle();
    check("err_core_reset", 32'(core_err_sticky), 32'd0);
    tick();
    reset = 1;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
